// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: load sizes, architectural register ids, MEM/WB record.
// No logic; types and constants only.
// Not applicable.
package mips_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memtoreg;
    logic        link;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [4:0]  write_register;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
  } memwb_t;

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-stage result bundle into writeback plus the register-file write port out of it.
// Wires only; no latency.
// No backpressure on this bundle; stalls travel on separate pipeline controls.
interface writeback_stage_if;

  logic        mem_valid;
  logic        mem_regwrite;
  logic        mem_memtoreg;
  logic        mem_link;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [4:0]  mem_write_register;
  logic [31:0] mem_alu_result;
  logic [31:0] mem_read_data;
  logic [31:0] mem_pc_plus4;

  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        regwrite;

  // Upstream/consumer view: supplies the MEM-stage bundle, observes the write port.
  modport master (
    output mem_valid, mem_regwrite, mem_memtoreg, mem_link, mem_size, mem_unsigned,
           mem_write_register, mem_alu_result, mem_read_data, mem_pc_plus4,
    input  write_register, write_data, regwrite
  );

  // Writeback stage view.
  modport slave (
    input  mem_valid, mem_regwrite, mem_memtoreg, mem_link, mem_size, mem_unsigned,
           mem_write_register, mem_alu_result, mem_read_data, mem_pc_plus4,
    output write_register, write_data, regwrite
  );

endinterface

// File: rtl/writeback_stage_load_extend.sv
// Picks the addressed byte/half lane out of an aligned load word and sign/zero extends it.
// Purely combinational.
// No flow control; flags offsets that do not fit the access size.
module load_extend
  import mips_pkg::*;
(
  input  logic [31:0] read_data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zero_ext,
  output logic [31:0] data,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Lane selection and extension; the half lane uses only offset[1], so an odd
  // half offset still returns a defined value even though it is flagged.
  always_comb begin
    byte_lane  = read_data[{offset, 3'b000} +: 8];
    half_lane  = offset[1] ? read_data[31:16] : read_data[15:0];
    data       = read_data;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: data = zero_ext ? {24'd0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: begin
        data       = zero_ext ? {16'd0, half_lane} : {{16{half_lane[15]}}, half_lane};
        misaligned = offset[0];
      end
      SZ_WORD: misaligned = (offset != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register, writeback source select and register-file write port.
// One cycle MEM -> WB; outputs are combinational from the registered state.
// stall holds MEM/WB (a held instruction re-issues the same write); flush inserts a bubble.
module writeback_stage
  import mips_pkg::*;
#(
  parameter int unsigned RETIRE_W = 32,
  parameter logic [4:0]  LINK_REG = REG_RA
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  writeback_stage_if.slave    wb_if,
  output logic                fwd_valid,
  output logic [4:0]          fwd_register,
  output logic [31:0]         fwd_data,
  output logic [RETIRE_W-1:0] retire_count,
  output logic                align_err
);

  memwb_t        wb_q;
  logic [31:0]   ld_data;
  logic          ld_mis;
  logic          misaligned;
  logic [4:0]    wr_reg;
  logic [31:0]   wr_data;
  logic          wr_en;
  logic          align_q;
  logic [RETIRE_W-1:0] retire_q;

  load_extend u_load_extend (
    .read_data  (wb_q.read_data),
    .offset     (wb_q.alu_result[1:0]),
    .size       (wb_q.size),
    .zero_ext   (wb_q.is_unsigned),
    .data       (ld_data),
    .misaligned (ld_mis)
  );

  // MEM/WB register: reset > flush > stall > capture. Flush only drops valid;
  // the stale fields are harmless because every write is qualified by valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q.valid <= 1'b0;
    end else if (!stall) begin
      wb_q.valid          <= wb_if.mem_valid;
      wb_q.regwrite       <= wb_if.mem_regwrite;
      wb_q.memtoreg       <= wb_if.mem_memtoreg;
      wb_q.link           <= wb_if.mem_link;
      wb_q.size           <= wb_if.mem_size;
      wb_q.is_unsigned    <= wb_if.mem_unsigned;
      wb_q.write_register <= wb_if.mem_write_register;
      wb_q.alu_result     <= wb_if.mem_alu_result;
      wb_q.read_data      <= wb_if.mem_read_data;
      wb_q.pc_plus4       <= wb_if.mem_pc_plus4;
    end
  end

  // Source select and write enable; link overrides both destination and data.
  always_comb begin
    misaligned = wb_q.memtoreg & ld_mis;
    wr_reg     = wb_q.write_register;
    wr_data    = wb_q.alu_result;
    if (wb_q.link) begin
      wr_reg  = LINK_REG;
      wr_data = wb_q.pc_plus4;
    end else if (wb_q.memtoreg) begin
      wr_data = ld_data;
    end
    wr_en = wb_q.valid & wb_q.regwrite & (wr_reg != REG_ZERO) & ~misaligned;
  end

  // Retire counter: an instruction retires on the edge it leaves WB unstalled,
  // whether or not it wrote a register (flush without stall still retires it).
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q <= '0;
    end else if (wb_q.valid && !stall) begin
      retire_q <= retire_q + RETIRE_W'(1);
    end
  end

  // Sticky misaligned-load record, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      align_q <= 1'b0;
    end else if (wb_q.valid && misaligned) begin
      align_q <= 1'b1;
    end
  end

  assign wb_if.write_register = wr_reg;
  assign wb_if.write_data     = wr_data;
  assign wb_if.regwrite       = wr_en;
  assign fwd_valid            = wr_en;
  assign fwd_register         = wr_reg;
  assign fwd_data             = wr_data;
  assign retire_count         = retire_q;
  // Visible in the same cycle the offending load sits in WB, then held.
  assign align_err            = align_q | (wb_q.valid & misaligned);

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        fwd_valid;
  logic [4:0]  fwd_register;
  logic [31:0] fwd_data;
  logic [31:0] retire_count;
  logic        align_err;

  int errors = 0;
  int checks = 0;

  writeback_stage_if bus ();

  writeback_stage #(.RETIRE_W(32), .LINK_REG(5'd31)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .wb_if        (bus),
    .fwd_valid    (fwd_valid),
    .fwd_register (fwd_register),
    .fwd_data     (fwd_data),
    .retire_count (retire_count),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  // Reference model: what instruction sits in WB, and the retire/alignment history.
  logic        m_v, m_rw, m_mtr, m_link, m_uns;
  logic [1:0]  m_size;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_rdata, m_pc4, m_ret;
  logic        m_aerr;

  function automatic logic model_mis();
    int o = int'(m_alu & 32'd3);
    if (!m_mtr) return 1'b0;
    if (m_size == 2'd1) return (o % 2) == 1;
    if (m_size == 2'd2) return o != 0;
    if (m_size == 2'd3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4:0] model_reg();
    return m_link ? 5'd31 : m_rd;
  endfunction

  function automatic logic [31:0] model_data();
    int o = int'(m_alu & 32'd3);
    logic [31:0] v;
    if (m_link) return m_pc4;
    if (!m_mtr) return m_alu;
    if (m_size == 2'd0) begin
      v = (m_rdata >> (8 * o)) & 32'hFF;
      if (!m_uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (m_size == 2'd1) begin
      v = (m_rdata >> (16 * (o / 2))) & 32'hFFFF;
      if (!m_uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = m_rdata;
    end
    return v;
  endfunction

  function automatic logic model_we();
    return m_v && m_rw && (model_reg() != 5'd0) && !model_mis();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".regwrite"}, {31'd0, bus.regwrite}, {31'd0, model_we()});
    chk({tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, model_we()});
    chk({tag, ".retire"}, retire_count, m_ret);
    if (!(m_v && model_mis())) chk({tag, ".align_err"}, {31'd0, align_err}, {31'd0, m_aerr});
    if (m_v) begin
      chk({tag, ".wr_reg"}, {27'd0, bus.write_register}, {27'd0, model_reg()});
      chk({tag, ".fwd_reg"}, {27'd0, fwd_register}, {27'd0, model_reg()});
      if (!(m_mtr && m_size == 2'd3 && !m_link)) begin
        chk({tag, ".wr_data"}, bus.write_data, model_data());
        chk({tag, ".fwd_data"}, fwd_data, model_data());
      end
    end
  endtask

  task automatic drive(input logic v, input logic rw, input logic mtr, input logic lnk,
                       input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] rdata, input logic [31:0] pc4);
    bus.mem_valid = v;  bus.mem_regwrite = rw; bus.mem_memtoreg = mtr; bus.mem_link = lnk;
    bus.mem_size = sz;  bus.mem_unsigned = uns; bus.mem_write_register = rd;
    bus.mem_alu_result = alu; bus.mem_read_data = rdata; bus.mem_pc_plus4 = pc4;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // One clock edge; the model advances by the same rules the inputs imply.
  task automatic tick();
    logic mis_now;
    mis_now = m_v && model_mis();
    @(posedge clk);
    if (rst) begin
      {m_v, m_rw, m_mtr, m_link, m_uns, m_size, m_rd} = '0;
      m_alu = '0; m_rdata = '0; m_pc4 = '0; m_ret = '0; m_aerr = 1'b0;
    end else begin
      if (m_v && !stall) m_ret = m_ret + 32'd1;
      if (mis_now) m_aerr = 1'b1;
      if (flush) m_v = 1'b0;
      else if (!stall) begin
        m_v = bus.mem_valid; m_rw = bus.mem_regwrite; m_mtr = bus.mem_memtoreg;
        m_link = bus.mem_link; m_size = bus.mem_size; m_uns = bus.mem_unsigned;
        m_rd = bus.mem_write_register; m_alu = bus.mem_alu_result;
        m_rdata = bus.mem_read_data; m_pc4 = bus.mem_pc_plus4;
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] r0;
    logic lnk, mtr;
    m_v = 0; m_rw = 0; m_mtr = 0; m_link = 0; m_uns = 0; m_size = 0; m_rd = 0;
    m_alu = 0; m_rdata = 0; m_pc4 = 0; m_ret = 0; m_aerr = 0;
    rst = 1; stall = 0; flush = 0;
    idle();

    // Reset, then idle.
    tick(); tick();
    chk("reset.regwrite", {31'd0, bus.regwrite}, 32'd0);
    chk("reset.write_data", bus.write_data, 32'd0);
    chk("reset.write_register", {27'd0, bus.write_register}, 32'd0);
    chk("reset.retire", retire_count, 32'd0);
    chk("reset.align_err", {31'd0, align_err}, 32'd0);
    rst = 0;
    tick();
    check_all("idle");

    // ALU write.
    drive(1, 1, 0, 0, 2'd2, 0, 5'd8, 32'h0000_1234, 32'hDEAD_BEEF, 32'h0);
    tick();
    chk("alu.regwrite", {31'd0, bus.regwrite}, 32'd1);
    chk("alu.write_register", {27'd0, bus.write_register}, 32'd8);
    chk("alu.write_data", bus.write_data, 32'h0000_1234);
    chk("alu.retire_before", retire_count, 32'd0);
    check_all("alu");
    idle();
    tick();
    chk("alu.retire_after", retire_count, 32'd1);

    // Signed / unsigned byte load at offset 2.
    drive(1, 1, 1, 0, 2'd0, 0, 5'd10, 32'h1000_0002, 32'h0080_0000, 32'h0);
    tick();
    chk("lb.signed", bus.write_data, 32'hFFFF_FF80);
    check_all("lb");
    drive(1, 1, 1, 0, 2'd0, 1, 5'd10, 32'h1000_0002, 32'h0080_0000, 32'h0);
    tick();
    chk("lbu.unsigned", bus.write_data, 32'h0000_0080);
    check_all("lbu");

    // Link.
    drive(1, 1, 0, 1, 2'd2, 0, 5'd5, 32'h0000_7777, 32'h0, 32'h0040_0010);
    tick();
    chk("link.write_register", {27'd0, bus.write_register}, 32'd31);
    chk("link.write_data", bus.write_data, 32'h0040_0010);
    chk("link.regwrite", {31'd0, bus.regwrite}, 32'd1);

    // Destination register 0 still retires.
    drive(1, 1, 0, 0, 2'd2, 0, 5'd0, 32'h55, 32'h0, 32'h0);
    tick();
    chk("r0.regwrite", {31'd0, bus.regwrite}, 32'd0);
    r0 = retire_count;
    idle();
    tick();
    chk("r0.retire_inc", retire_count, r0 + 32'd1);

    // Misaligned half load.
    chk("mis.align_before", {31'd0, align_err}, 32'd0);
    drive(1, 1, 1, 0, 2'd1, 0, 5'd12, 32'h2000_0001, 32'h1234_5678, 32'h0);
    tick();
    chk("mis.regwrite", {31'd0, bus.regwrite}, 32'd0);
    idle();
    tick();
    chk("mis.align_set", {31'd0, align_err}, 32'd1);
    tick(); tick();
    chk("mis.align_sticky", {31'd0, align_err}, 32'd1);

    // Stall three cycles with dest=9 in WB.
    drive(1, 1, 0, 0, 2'd2, 0, 5'd9, 32'h0000_0999, 32'h0, 32'h0);
    tick();
    r0 = retire_count;
    stall = 1;
    drive(1, 1, 0, 0, 2'd2, 0, 5'd20, 32'hAAAA_AAAA, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall.regwrite", {31'd0, bus.regwrite}, 32'd1);
      chk("stall.write_register", {27'd0, bus.write_register}, 32'd9);
      chk("stall.write_data", bus.write_data, 32'h0000_0999);
    end
    chk("stall.retire_held", retire_count, r0);
    stall = 0;
    tick();
    chk("stall.retire_once", retire_count, r0 + 32'd1);
    check_all("stall_release");

    // flush+stall together: bubble, no retire.
    r0 = retire_count;
    stall = 1; flush = 1;
    tick();
    chk("flush_stall.regwrite", {31'd0, bus.regwrite}, 32'd0);
    chk("flush_stall.retire", retire_count, r0);
    stall = 0; flush = 0;
    idle();
    tick();
    check_all("post_flush");

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      lnk = ($urandom_range(0, 5) == 0);
      mtr = lnk ? 1'b0 : 1'($urandom_range(0, 1));
      drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0), mtr, lnk,
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            $urandom, $urandom, $urandom);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 59) == 0);
      tick();
      check_all("rand");
    end

    // Reset mid-stall clears everything, including the sticky flag.
    stall = 1; rst = 1;
    tick();
    chk("rst_stall.retire", retire_count, 32'd0);
    chk("rst_stall.align", {31'd0, align_err}, 32'd0);
    chk("rst_stall.regwrite", {31'd0, bus.regwrite}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Write-side master for the 32x32 register file: holds the MEM/WB pipeline register and formats load data.
- Selects the writeback source and drives the register-file write port: write_register, write_data, regwrite.
- Sits between the data-memory stage and the register file.
- Also exports the WB destination/value for forwarding, an instruction-retire counter, and a sticky misaligned-load flag.

Parameters:
- RETIRE_W, 32, width of retire counter (wraps modulo 2^RETIRE_W)
- LINK_REG, 31, destination forced for link (jal/jalr) writes

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- stall  in  1  hold MEM/WB register contents
- flush  in  1  load a bubble into MEM/WB
- mem_valid  in  1  MEM stage holds a real instruction
- mem_regwrite  in  1  instruction writes a register
- mem_memtoreg  in  1  source is load data (else ALU result)
- mem_link  in  1  source is pc_plus4, destination LINK_REG
- mem_size  in  2  load size: 00 byte, 01 half, 10 word
- mem_unsigned  in  1  zero-extend (else sign-extend) byte/half loads
- mem_write_register  in  5  destination register
- mem_alu_result  in  32  ALU result; bits [1:0] are the load byte offset
- mem_read_data  in  32  raw aligned word from data memory
- mem_pc_plus4  in  32  link value
- write_register  out  5  to register file
- write_data  out  32  to register file
- regwrite  out  1  to register file
- fwd_valid  out  1  equals regwrite (forwarding qualifier)
- fwd_register  out  5  equals write_register
- fwd_data  out  32  equals write_data
- retire_count  out  RETIRE_W  instructions retired since reset
- align_err  out  1  sticky misaligned-load flag

Behaviour:
- Reset: synchronous, active-high. On a posedge with rst=1: MEM/WB valid=0, all captured fields=0, retire_count=0, align_err=0. Hence regwrite=0, write_register=0, write_data=0.
- Priority at each posedge: rst > flush > stall > capture.
  - flush: wb_valid<=0; other fields don't-care, but must not cause regwrite.
  - stall (and no flush): all MEM/WB fields hold.
  - capture: all mem_* fields registered; 1-cycle latency MEM -> WB.
- Outputs are combinational from MEM/WB state, stable for the full cycle before the next posedge.
- Source select:
  - link=1 overrides: write_register=LINK_REG, write_data=pc_plus4.
  - else memtoreg=1: write_data=extended load, write_register=captured destination.
  - else: write_data=alu_result, write_register=captured destination.
- Load extension, offset o=alu_result[1:0]:
  - byte: lane = read_data[8*o+7:8*o].
  - half: lane = read_data[16*o[1]+15:16*o[1]].
  - word: full 32 bits.
  - Sign- or zero-extend the lane per unsigned.
- Misaligned load: memtoreg with half and o[0]=1, or word and o!=0, or size=11.
  - regwrite forced 0.
  - align_err set while wb_valid=1; sticky until rst.
- regwrite = wb_valid & wb_regwrite & (write_register!=0) & !misaligned. A destination of register 0 never asserts regwrite.
- Stalled valid instruction re-asserts the identical write every cycle (idempotent).
- retire_count increments on a posedge when wb_valid=1 and stall=0 and rst=0, including misaligned and non-writing instructions. Wraps to 0.
- Simultaneous flush+stall: flush wins. An instruction in WB leaves on that edge and counts as retired only if stall=0.
- Reset mid-stall: reset wins; state cleared the same edge.

Decomposition:
- Shared package mips_pkg: SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10; REG_ZERO=5'd0; REG_RA=5'd31.
- One combinational sub-module load_extend: (read_data, offset, size, unsigned) -> (data, misaligned).

Test Plan:
- Reset then idle: rst=1 two cycles, mem_valid=0 -> regwrite=0, write_data=0, retire_count=0, align_err=0.
- ALU write: valid, regwrite, dest=8, alu=0x0000_1234 -> next cycle regwrite=1, write_register=8, write_data=0x1234. retire_count 0->1 after the following edge.
- Load byte signed at offset 2: read_data=0x0080_0000 -> write_data=0xFFFF_FF80. With unsigned=1 -> 0x0000_0080.
- Link: link=1, dest=5, pc_plus4=0x0040_0010 -> write_register=31, write_data=0x0040_0010, regwrite=1.
- Register 0 and misalign:
  - dest=0 -> regwrite=0, retire still increments.
  - half load offset 1 -> regwrite=0, align_err=1, stays 1 until rst.
- Stall/flush:
  - Stall 3 cycles with dest=9 in WB -> regwrite=1 all 3 cycles, retire increments once.
  - flush+stall together -> next cycle regwrite=0.
